// File: rtl/rx_frontend_cfg_pkg.sv
// Shared types and helpers for the configurable UART receive front end.
package rx_frontend_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef struct packed {
        logic [3:0] data_bits;
        logic [1:0] parity_mode;
        logic       stop2;
    } rx_cfg_t;

    // Clamp the requested word length into 5..9 and then to the physical width.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                   input logic [3:0] max_bits);
        logic [3:0] v;
        if (req < 4'd5) begin
            v = 4'd5;
        end else if (req > 4'd9) begin
            v = 4'd9;
        end else begin
            v = req;
        end
        if (v > max_bits) begin
            v = max_bits;
        end else begin
            v = v;
        end
        return v;
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_frontend_cfg_tick.sv
// Sample-tick divider: restartable down-counter plus per-bit tick index.
module rx_tick_gen #(
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV_W  = 16,
    parameter int IDX_W      = $clog2(OVERSAMPLE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_restart,
    input  logic [CLK_DIV_W-1:0] i_clk_div,
    output logic                 o_tick,
    output logic [IDX_W-1:0]     o_tick_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OVERSAMPLE - 1);

    logic [CLK_DIV_W-1:0] r_cnt;
    logic [CLK_DIV_W-1:0] w_reload;
    logic                 r_tick;
    logic [IDX_W-1:0]     r_idx;

    // A divider of 0 behaves as 1 so the counter can never stall.
    assign w_reload = (i_clk_div == '0) ? {CLK_DIV_W{1'b0}} : (i_clk_div - CLK_DIV_W'(1));

    // Down-counter emitting one tick per reload; index names the tick currently high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_idx  <= '0;
        end else if (i_restart) begin
            r_cnt  <= w_reload;
            r_tick <= 1'b0;
            r_idx  <= '0;
        end else begin
            if (r_cnt == '0) begin
                r_cnt  <= w_reload;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt - CLK_DIV_W'(1);
                r_tick <= 1'b0;
            end
            if (r_tick) begin
                r_idx <= (r_idx == LAST_IDX) ? {IDX_W{1'b0}} : (r_idx + IDX_W'(1));
            end else begin
                r_idx <= r_idx;
            end
        end
    end

    assign o_tick     = r_tick;
    assign o_tick_idx = r_idx;

endmodule

// File: rtl/rx_frontend_cfg.sv
// Configurable UART receive front end: synchronise, oversample, majority-vote, deframe.
module rx_frontend_cfg
    import rx_frontend_cfg_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int CLK_DIV_W     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [CLK_DIV_W-1:0]     clk_div_i,
    input  logic [3:0]               data_bits_i,
    input  logic [1:0]               parity_mode_i,
    input  logic                     stop_bits_i,
    input  logic                     uart_rx_i,
    output logic [MAX_DATA_BITS-1:0] data_o,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     break_o,
    output logic                     output_valid_o
);

    localparam int               IDX_W  = $clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] SAMP_A = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] SAMP_B = IDX_W'(OVERSAMPLE / 2);
    localparam logic [IDX_W-1:0] SAMP_C = IDX_W'(OVERSAMPLE / 2 + 1);

    rx_state_e state_q;
    rx_state_e w_state_d;

    logic r_sync1, r_sync2, r_sync3;
    logic w_fall;
    logic w_tick;
    logic [IDX_W-1:0] w_tick_idx;
    logic [1:0] r_samp;
    logic w_vote_valid, w_vote;
    logic w_restart, w_emit;

    rx_cfg_t                  r_cfg;
    logic [3:0]               r_bit_cnt;
    logic [MAX_DATA_BITS-1:0] r_shift;
    logic                     r_par_acc, r_par_err, r_frame_err, r_any_one, r_stop_seen;

    logic [MAX_DATA_BITS-1:0] r_data;
    logic                     r_pe, r_fe, r_brk, r_valid;

    // Two-flop synchroniser plus edge register, all idling high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_fall = r_sync3 & ~r_sync2;

    rx_tick_gen #(
        .OVERSAMPLE (OVERSAMPLE),
        .CLK_DIV_W  (CLK_DIV_W),
        .IDX_W      (IDX_W)
    ) u_tick (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_restart  (w_restart),
        .i_clk_div  (clk_div_i),
        .o_tick     (w_tick),
        .o_tick_idx (w_tick_idx)
    );

    // Capture the first two mid-bit samples; the third is taken live at the vote tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_samp <= 2'b11;
        end else if (w_tick && (w_tick_idx == SAMP_A)) begin
            r_samp[0] <= r_sync2;
        end else if (w_tick && (w_tick_idx == SAMP_B)) begin
            r_samp[1] <= r_sync2;
        end else begin
            r_samp <= r_samp;
        end
    end

    assign w_vote_valid = w_tick && (w_tick_idx == SAMP_C);
    assign w_vote       = majority3(r_samp[0], r_samp[1], r_sync2);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= w_state_d;
        end
    end

    // Next-state logic and the restart/emit strobes.
    always_comb begin
        w_state_d = state_q;
        w_restart = 1'b0;
        w_emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_fall) begin
                    w_state_d = START;
                    w_restart = 1'b1;
                end else begin
                    w_state_d = IDLE;
                end
            end
            START: begin
                if (w_vote_valid) begin
                    w_state_d = w_vote ? IDLE : DATA;
                end else begin
                    w_state_d = START;
                end
            end
            DATA: begin
                if (w_vote_valid && (r_bit_cnt == (r_cfg.data_bits - 4'd1))) begin
                    w_state_d = parity_enabled(r_cfg.parity_mode) ? PARITY : STOP;
                end else begin
                    w_state_d = DATA;
                end
            end
            PARITY: begin
                if (w_vote_valid) begin
                    w_state_d = STOP;
                end else begin
                    w_state_d = PARITY;
                end
            end
            STOP: begin
                if (w_vote_valid && (!r_cfg.stop2 || r_stop_seen)) begin
                    w_emit    = 1'b1;
                    w_state_d = (r_frame_err || !w_vote) ? WAIT_IDLE : IDLE;
                end else begin
                    w_state_d = STOP;
                end
            end
            WAIT_IDLE: begin
                if (r_sync2) begin
                    w_state_d = IDLE;
                end else begin
                    w_state_d = WAIT_IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Frame datapath: config capture, LSB-first shift, parity and stop tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg       <= '0;
            r_bit_cnt   <= 4'd0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_any_one   <= 1'b0;
            r_stop_seen <= 1'b0;
        end else if (w_restart) begin
            r_cfg.data_bits   <= clamp_data_bits(data_bits_i, 4'(MAX_DATA_BITS));
            r_cfg.parity_mode <= parity_mode_i;
            r_cfg.stop2       <= stop_bits_i;
            r_bit_cnt         <= 4'd0;
            r_shift           <= '0;
            r_par_acc         <= 1'b0;
            r_par_err         <= 1'b0;
            r_frame_err       <= 1'b0;
            r_any_one         <= 1'b0;
            r_stop_seen       <= 1'b0;
        end else if (w_vote_valid) begin
            case (state_q)
                DATA: begin
                    r_shift[r_bit_cnt] <= w_vote;
                    r_bit_cnt          <= r_bit_cnt + 4'd1;
                    r_par_acc          <= r_par_acc ^ w_vote;
                    r_any_one          <= r_any_one | w_vote;
                end
                PARITY: begin
                    r_par_err <= w_vote ^ r_par_acc ^ (r_cfg.parity_mode == PAR_ODD);
                    r_any_one <= r_any_one | w_vote;
                end
                STOP: begin
                    r_stop_seen <= 1'b1;
                    r_frame_err <= r_frame_err | ~w_vote;
                    // Only the first stop bit participates in break detection.
                    r_any_one   <= r_any_one | (w_vote & ~r_stop_seen);
                end
                default: begin
                    r_bit_cnt <= r_bit_cnt;
                end
            endcase
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // Registered result word and flags, updated only when a frame completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data  <= '0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_brk   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_data <= r_shift;
                r_pe   <= r_par_err;
                r_fe   <= r_frame_err | ~w_vote;
                r_brk  <= ~(r_any_one | (w_vote & ~r_stop_seen));
            end else begin
                r_data <= r_data;
            end
        end
    end

    assign data_o         = r_data;
    assign parity_err_o   = r_pe;
    assign frame_err_o    = r_fe;
    assign break_o        = r_brk;
    assign output_valid_o = r_valid;

endmodule

// File: tb/tb_rx_frontend_cfg.sv
// Directed bench for rx_frontend_cfg: hand-built frames at 64 clocks per bit.
module tb_rx_frontend_cfg;
    import rx_frontend_cfg_pkg::*;

    localparam int BIT_CYC = 64;

    logic        clk;
    logic        rst_n;
    logic [15:0] clk_div;
    logic [3:0]  data_bits;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic        rx;
    logic [8:0]  data;
    logic        parity_err, frame_err, brk, valid;

    int vectors;
    int miscompares;
    int pulses;
    int p0;
    logic [8:0] cap_data;
    logic       cap_pe, cap_fe, cap_brk;
    logic       prev_valid;
    rx_state_e  post_state;

    rx_frontend_cfg dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clk_div_i      (clk_div),
        .data_bits_i    (data_bits),
        .parity_mode_i  (parity_mode),
        .stop_bits_i    (stop_bits),
        .uart_rx_i      (rx),
        .data_o         (data),
        .parity_err_o   (parity_err),
        .frame_err_o    (frame_err),
        .break_o        (brk),
        .output_valid_o (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts valid cycles, latches the qualified word, records state one cycle later.
    always @(negedge clk) begin
        if (valid) begin
            pulses   <= pulses + 1;
            cap_data <= data;
            cap_pe   <= parity_err;
            cap_fe   <= frame_err;
            cap_brk  <= brk;
        end
        if (prev_valid) post_state <= dut.state_q;
        prev_valid <= valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input bit par_en,
                              input logic pb, input logic s1, input bit two, input logic s2);
        logic [8:0] dv;
        dv = d;
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(dv[i]);
        if (par_en) send_bit(pb);
        send_bit(s1);
        if (two) send_bit(s2);
        rx = 1'b1;
        repeat (128) @(negedge clk);
    endtask

    task automatic check_word(input string tag, input logic [8:0] d, input logic pe,
                              input logic fe, input logic bk);
        check({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
        check({tag, "_data"},   32'(cap_data),    32'(d));
        check({tag, "_perr"},   32'(cap_pe),      32'(pe));
        check({tag, "_ferr"},   32'(cap_fe),      32'(fe));
        check({tag, "_break"},  32'(cap_brk),     32'(bk));
    endtask

    initial begin
        vectors = 0; miscompares = 0; pulses = 0; prev_valid = 1'b0;
        cap_data = 9'd0; cap_pe = 1'b0; cap_fe = 1'b0; cap_brk = 1'b0;
        post_state = IDLE;
        rst_n = 1'b0; rx = 1'b1; clk_div = 16'd4;
        data_bits = 4'd8; parity_mode = PAR_NONE; stop_bits = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_data",  32'(data),        32'd0);
        check("rst_flags", {29'd0, parity_err, frame_err, brk}, 32'd0);
        check("rst_valid", 32'(valid),       32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0xA5
        p0 = pulses;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_word("8n1_a5", 9'h0A5, 1'b0, 1'b0, 1'b0);
        check("8n1_post_state", 32'(post_state), 32'(IDLE));

        // 7E1 0x35 with wrong parity bit
        data_bits = 4'd7; parity_mode = PAR_EVEN;
        p0 = pulses;
        send_frame(9'h035, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check_word("7e1_35", 9'h035, 1'b1, 1'b0, 1'b0);

        // 9O1 0x1FF, correct then wrong parity
        data_bits = 4'd9; parity_mode = PAR_ODD;
        p0 = pulses;
        send_frame(9'h1FF, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_word("9o1_ok", 9'h1FF, 1'b0, 1'b0, 1'b0);
        p0 = pulses;
        send_frame(9'h1FF, 9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check_word("9o1_bad", 9'h1FF, 1'b1, 1'b0, 1'b0);

        // Short glitch: start detected, then rejected by the start vote
        data_bits = 4'd8; parity_mode = PAR_NONE;
        p0 = pulses;
        rx = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_start", 32'(dut.state_q), 32'(START));
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (128) @(negedge clk);
        check("glitch_idle",   32'(dut.state_q), 32'(IDLE));
        check("glitch_pulses", 32'(pulses - p0), 32'd0);

        // Word length below range clamps to 5
        data_bits = 4'd4;
        p0 = pulses;
        send_frame(9'h015, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_word("clamp5", 9'h015, 1'b0, 1'b0, 1'b0);

        // 8N2 with second stop bit low
        data_bits = 4'd8; stop_bits = 1'b1;
        p0 = pulses;
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_word("8n2_stop2", 9'h05A, 1'b0, 1'b1, 1'b0);

        // Break: line low for 20 bit times
        p0 = pulses;
        rx = 1'b0;
        repeat (20 * BIT_CYC) @(negedge clk);
        check_word("break", 9'h000, 1'b0, 1'b1, 1'b1);
        check("break_wait", 32'(dut.state_q), 32'(WAIT_IDLE));
        rx = 1'b1;
        repeat (128) @(negedge clk);
        check("break_no_more", 32'(pulses - p0), 32'd1);
        check("break_idle",    32'(dut.state_q), 32'(IDLE));

        // Reset during data bit 4 of a 0x3C frame
        stop_bits = 1'b0;
        p0 = pulses;
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        check("mid_rst_out",   {22'd0, data, parity_err, frame_err, brk}, 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;
        repeat (128) @(negedge clk);
        check("mid_rst_pulses", 32'(pulses - p0), 32'd0);
        p0 = pulses;
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_word("after_rst_3c", 9'h03C, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_frontend_cfg.md
# rx_frontend_cfg

Parametrised UART receive front end: synchronises the raw RX line, oversamples it with a programmable sample tick, majority-votes each bit and deframes runtime-configurable frames of 5–9 data bits, with none/even/odd parity and 1 or 2 stop bits. It reports parity, framing and break conditions alongside each received word. It sits between the `uart_rx_i` pad and the RX FIFO / register front end of the Wishbone UART, replacing the fixed-format receive front end.

## Interface
Parameters:
- `OVERSAMPLE`, 16: sample ticks per bit. Even, ≥ 8.
- `MAX_DATA_BITS`, 9: width of `data_o`. Range 5..9.
- `CLK_DIV_W`, 16: width of `clk_div_i`.

Ports:
- `clk_i`  in  1  single system clock; all state on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `clk_div_i`  in  CLK_DIV_W  clk_i cycles per sample tick; 0 is treated as 1.
- `data_bits_i`  in  4  data bits per frame, 5..9; values outside the range clamp to the nearest limit and to MAX_DATA_BITS.
- `parity_mode_i`  in  2  00 none, 01 even, 10 odd, 11 none.
- `stop_bits_i`  in  1  0 = one stop bit, 1 = two.
- `uart_rx_i`  in  1  asynchronous RX line, idle high.
- `data_o`  out  MAX_DATA_BITS  received word, right-aligned, upper unused bits 0.
- `parity_err_o`  out  1  parity mismatch for this word.
- `frame_err_o`  out  1  a stop sample voted 0.
- `break_o`  out  1  data, parity and first stop all 0.
- `output_valid_o`  out  1  single-cycle pulse qualifying the four outputs above.

## Operation
- Input path: a 2-flop synchroniser whose flops reset to 1, then an edge detector on the synchronised value.
- Tick generator: a counter that restarts at start detection and emits a one-cycle tick every max(`clk_div_i`, 1) cycles. A change to `clk_div_i` takes effect at the next reload. It must never hang.
- Bit vote: samples are taken at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within each bit. The bit value is the 2-of-3 majority.
- `data_bits_i`, `parity_mode_i` and `stop_bits_i` are captured at start detection and held for the frame.
- FSM `state_q`:
  - IDLE: on a falling edge → START (counters cleared).
  - START: a vote of 1 is a false start → IDLE, no output. A vote of 0 → DATA.
  - DATA: shift LSB first. After N bits → PARITY if parity is enabled, else STOP.
  - PARITY: compare the voted bit against the XOR of the data bits (even) or its inverse (odd).
  - STOP: vote 1 or 2 stop bits. A second stop bit is still checked even if the first failed.
  - After the final stop vote, pulse `output_valid_o`. Then go to IDLE if all stop votes were 1, else WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronised line is 1 → IDLE. No new start is detected while in this state.
- Output flags: `break_o` implies `frame_err_o`. `parity_err_o` is 0 when parity is disabled.

## Timing
- Reset state: `state_q`=IDLE, all outputs 0, synchroniser 1. Reset is honoured mid-frame with no pulse emitted.
- `data_o` and the error flags are registered and hold their value until the next pulse. `output_valid_o` is high for exactly one cycle per frame.
- Start detection: 3 clk_i cycles after `uart_rx_i` falls (2 synchroniser cycles + 1 edge register).
- `output_valid_o` rises 1 cycle after the tick that completes the final stop vote. That tick is the OVERSAMPLE/2+1 tick of the last stop bit, counted from start detection.
- Back-to-back frames: a falling edge arriving in the cycle IDLE is re-entered is detected.
- There is no backpressure. The consumer must accept each pulse; words are never stalled or buffered here.

## Structure
- Package `rx_frontend_cfg_pkg` holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE;
  - parity-mode constants: PAR_NONE, PAR_EVEN, PAR_ODD;
  - the `rx_cfg_t` struct for the captured configuration.
- Sub-module `rx_tick_gen`: the divider counter with restart input, producing the tick and the per-bit tick index.
- `state_q` is exposed to the bench.

## Test plan
All scenarios use `clk_div_i`=4 and OVERSAMPLE=16, giving 64 cycles per bit.
- 8N1, byte 0xA5 → one pulse with `data_o`=0x0A5 and all flags 0. `state_q` is back at IDLE the next cycle.
- 7E1, data 0x35, parity bit sent as 1 → `data_o`=0x035, `parity_err_o`=1, `frame_err_o`=0.
- 9O1, data 0x1FF, parity bit 0 → `data_o`=0x1FF, `parity_err_o`=0. Repeat with parity bit 1 → `parity_err_o`=1.
- Glitch: line low for 3 sample ticks, then high → no pulse, and `state_q` returns to IDLE.
- 8N2 with the second stop bit 0 → `frame_err_o`=1 and `break_o`=0. Line low for 20 bit times → `data_o`=0, `frame_err_o`=1, `break_o`=1, then no further pulse until the line rises.
- Reset asserted during data bit 4 → all outputs 0 and `state_q`=IDLE. A following 8N1 frame of 0x3C is received correctly.
